// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: the imem requester, the dmem requester and the
// shared downstream memory port. The slave modport is the arbiter's view; the
// master modport is the view of whatever drives requests and answers the memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128
);
    // imem requester (read only)
    logic                  i_stb;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_resp;
    // dmem requester
    logic                  d_stb;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_resp;
    // downstream memory port
    logic                  m_cyc;
    logic                  m_stb;
    logic                  m_we;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic                  m_resp;

    modport slave (
        input  i_stb, i_addr, d_stb, d_we, d_addr, d_wdata, m_rdata, m_resp,
        output i_rdata, i_resp, d_rdata, d_resp, m_cyc, m_stb, m_we, m_addr, m_wdata
    );

    modport master (
        output i_stb, i_addr, d_stb, d_we, d_addr, d_wdata, m_rdata, m_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, m_cyc, m_stb, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between the fetch-stage imem
// port and the mem-stage dmem port. A request is latched at grant and held on the
// downstream bus until m_resp; the completion and read line go back only to the
// requester that owns the transaction. A DONE dead cycle follows every completion so
// a requester's stale strobe is never granted twice.
// Optional build macro ARB_ROUND_ROBIN_EN: ties alternate sides instead of always
// favouring dmem.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus,
    output logic [CNT_WIDTH-1:0] contention
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_m_we;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic [DATA_WIDTH-1:0] r_m_wdata;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic [CNT_WIDTH-1:0]  r_contention;

    logic w_busy;
    logic w_busy_i;
    logic w_busy_d;
    logic w_grant_i;
    logic w_grant_d;
    logic w_tie;
    logic w_tie_to_d;
    logic w_i_resp;
    logic w_d_resp;

    assign w_busy_i = (r_state == BUSY_I);
    assign w_busy_d = (r_state == BUSY_D);
    assign w_busy   = w_busy_i | w_busy_d;
    assign w_tie    = bus.i_stb & bus.d_stb;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = dmem got the most recent grant; reset value means imem, so the first tie goes to dmem
    logic r_last_grant_d;

    assign w_tie_to_d = ~r_last_grant_d;

    // Remember which side was granted last so the next tie goes the other way
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant_d <= 1'b0;
        end else if (w_grant_d) begin
            r_last_grant_d <= 1'b1;
        end else if (w_grant_i) begin
            r_last_grant_d <= 1'b0;
        end
    end
`else
    // Fixed priority: the mem stage is older in the pipeline, so dmem wins every tie
    assign w_tie_to_d = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and grant decode; grants are only issued from IDLE
    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.d_stb && (!bus.i_stb || w_tie_to_d)) begin
                    w_grant_d    = 1'b1;
                    w_state_next = BUSY_D;
                end else if (bus.i_stb) begin
                    w_grant_i    = 1'b1;
                    w_state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.m_resp) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Capture the winning request at grant; it stays frozen until the next grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
        end else if (w_grant_d) begin
            r_m_we    <= bus.d_we;
            r_m_addr  <= bus.d_addr;
            r_m_wdata <= bus.d_wdata;
        end else if (w_grant_i) begin
            r_m_we    <= 1'b0;
            r_m_addr  <= bus.i_addr;
        end
    end

    // Keep a copy of the last line returned to each requester for when it is not being served
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_i_resp) begin
                r_i_rdata <= bus.m_rdata;
            end
            if (w_d_resp) begin
                r_d_rdata <= bus.m_rdata;
            end
        end
    end

    // Count IDLE cycles in which both sides were asking; stick at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_contention <= '0;
        end else if ((r_state == IDLE) && w_tie && (r_contention != {CNT_WIDTH{1'b1}})) begin
            r_contention <= r_contention + 1'b1;
        end
    end

    // m_resp only counts while a transaction is open, so a stray one in IDLE/DONE is dropped
    assign w_i_resp = w_busy_i & bus.m_resp;
    assign w_d_resp = w_busy_d & bus.m_resp;

    assign bus.i_resp  = w_i_resp;
    assign bus.d_resp  = w_d_resp;
    assign bus.i_rdata = w_busy_i ? bus.m_rdata : r_i_rdata;
    assign bus.d_rdata = w_busy_d ? bus.m_rdata : r_d_rdata;
    assign bus.m_cyc   = w_busy;
    assign bus.m_stb   = w_busy;
    assign bus.m_we    = r_m_we;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign contention  = r_contention;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change and outputs are sampled on the
// falling edge; combinational responses are sampled 1 time unit after the change.
// A second instance with a 2-bit contention counter shows the saturation boundary.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 128;

    localparam logic [DW-1:0] LINE_A5 = {16{8'hA5}};
    localparam logic [DW-1:0] LINE_0F = {16{8'h0F}};
    localparam logic [DW-1:0] LINE_3C = {16{8'h3C}};
    localparam logic [DW-1:0] LINE_FF = {16{8'hFF}};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] contention;
    logic [1:0]  contention_s;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_s ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .contention (contention)
    );

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_s.slave),
        .contention (contention_s)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the downstream cycle to open; an expired budget is a failed check
    task automatic wait_busy(input string tag);
        for (int k = 0; k < 8 && bus.m_cyc !== 1'b1; k++) @(negedge clk);
        chk(tag, 128'(bus.m_cyc), 128'(1));
    endtask

    initial begin
        logic          exp_d;
        logic [DW-1:0] rd;

        rst = 1'b1;
        bus.i_stb = 1'b0;   bus.i_addr = '0;
        bus.d_stb = 1'b0;   bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_rdata = '0;   bus.m_resp = 1'b0;
        bus_s.i_stb = 1'b0; bus_s.i_addr = '0;
        bus_s.d_stb = 1'b0; bus_s.d_we = 1'b0; bus_s.d_addr = '0; bus_s.d_wdata = '0;
        bus_s.m_rdata = '0; bus_s.m_resp = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_m_cyc",  128'(bus.m_cyc),  128'(0));
        chk("rst_m_stb",  128'(bus.m_stb),  128'(0));
        chk("rst_m_we",   128'(bus.m_we),   128'(0));
        chk("rst_m_addr", 128'(bus.m_addr), 128'(0));
        chk("rst_m_wdata", bus.m_wdata,     128'(0));
        chk("rst_i_resp", 128'(bus.i_resp), 128'(0));
        chk("rst_d_resp", 128'(bus.d_resp), 128'(0));
        chk("rst_contention", 128'(contention), 128'(0));
        rst = 1'b0;
        tick();

        // 1: imem read, m_resp on the third m_cyc cycle
        bus.i_stb = 1'b1; bus.i_addr = 16'h0040;
        tick();
        chk("t1_m_cyc",  128'(bus.m_cyc),  128'(1));
        chk("t1_m_stb",  128'(bus.m_stb),  128'(1));
        chk("t1_m_we",   128'(bus.m_we),   128'(0));
        chk("t1_m_addr", 128'(bus.m_addr), 128'(16'h0040));
        chk("t1_i_resp_early", 128'(bus.i_resp), 128'(0));
        repeat (2) tick();
        bus.m_resp = 1'b1; bus.m_rdata = LINE_A5;
        #1;
        chk("t1_i_resp",  128'(bus.i_resp), 128'(1));
        chk("t1_i_rdata", bus.i_rdata,      LINE_A5);
        chk("t1_d_resp",  128'(bus.d_resp), 128'(0));
        $display("txn 1 side=I addr=%h we=%0d rdata=%h", bus.m_addr, bus.m_we, bus.i_rdata);
        tick();
        bus.i_stb = 1'b0;
        #1;
        // m_resp still high but the transaction is closed: no second pulse
        chk("t1_i_resp_once", 128'(bus.i_resp), 128'(0));
        chk("t1_m_cyc_drop",  128'(bus.m_cyc),  128'(0));
        bus.m_resp = 1'b0; bus.m_rdata = '0;
        #1;
        chk("t1_i_rdata_hold", bus.i_rdata, LINE_A5);
        tick();

        // 2: dmem write; dmem drops its strobe mid-transaction
        bus.d_stb = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h1230; bus.d_wdata = LINE_0F;
        tick();
        chk("t2_m_cyc",   128'(bus.m_cyc),  128'(1));
        chk("t2_m_we",    128'(bus.m_we),   128'(1));
        chk("t2_m_addr",  128'(bus.m_addr), 128'(16'h1230));
        chk("t2_m_wdata", bus.m_wdata,      LINE_0F);
        bus.d_stb = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        tick();
        chk("t2_hold_cyc",   128'(bus.m_cyc),  128'(1));
        chk("t2_hold_addr",  128'(bus.m_addr), 128'(16'h1230));
        chk("t2_hold_wdata", bus.m_wdata,      LINE_0F);
        bus.m_resp = 1'b1; bus.m_rdata = LINE_3C;
        #1;
        chk("t2_d_resp",  128'(bus.d_resp), 128'(1));
        chk("t2_i_resp",  128'(bus.i_resp), 128'(0));
        chk("t2_d_rdata", bus.d_rdata,      LINE_3C);
        chk("t2_i_rdata_untouched", bus.i_rdata, LINE_A5);
        $display("txn 2 side=D addr=%h we=%0d wdata=%h", bus.m_addr, bus.m_we, bus.m_wdata);
        tick();
        bus.m_resp = 1'b0;
        #1;
        chk("t2_d_resp_once", 128'(bus.d_resp), 128'(0));
        chk("t2_m_cyc_drop",  128'(bus.m_cyc),  128'(0));
        tick();

        // 3: both requesters held high for three back-to-back rounds
        chk("t3_contention_before", 128'(contention), 128'(0));
        bus.i_stb = 1'b1; bus.i_addr = 16'h0100;
        bus.d_stb = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0200;
        for (int r = 0; r < 3; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (r % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            wait_busy("t3_grant_timeout");
            chk("t3_m_addr", 128'(bus.m_addr), exp_d ? 128'(16'h0200) : 128'(16'h0100));
            chk("t3_m_we",   128'(bus.m_we),   128'(0));
            rd = {4{32'hC0DE0000 + 32'(r)}};
            bus.m_resp = 1'b1; bus.m_rdata = rd;
            #1;
            chk("t3_d_resp", 128'(bus.d_resp), 128'(exp_d));
            chk("t3_i_resp", 128'(bus.i_resp), 128'(!exp_d));
            chk("t3_rdata", exp_d ? bus.d_rdata : bus.i_rdata, rd);
            $display("txn 3.%0d side=%s addr=%h contention=%0d", r, bus.d_resp ? "D" : "I",
                     bus.m_addr, contention);
            tick();
            bus.m_resp = 1'b0;
            if (r == 2) begin
                bus.i_stb = 1'b0; bus.d_stb = 1'b0;
            end
        end
        chk("t3_contention", 128'(contention), 128'(3));
        repeat (2) tick();
        chk("t3_no_stale_grant", 128'(bus.m_cyc), 128'(0));

        // 4: reset while BUSY_D, downstream answers two cycles later
        bus.d_stb = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0555; bus.d_wdata = LINE_FF;
        wait_busy("t4_grant_timeout");
        chk("t4_m_addr", 128'(bus.m_addr), 128'(16'h0555));
        rst = 1'b1; bus.d_stb = 1'b0; bus.d_we = 1'b0;
        tick();
        chk("t4_m_cyc_after_rst", 128'(bus.m_cyc), 128'(0));
        chk("t4_contention",      128'(contention), 128'(0));
        rst = 1'b0;
        tick();
        bus.m_resp = 1'b1; bus.m_rdata = LINE_3C;
        #1;
        chk("t4_late_d_resp", 128'(bus.d_resp), 128'(0));
        chk("t4_late_i_resp", 128'(bus.i_resp), 128'(0));
        $display("txn 4 side=D addr=0555 aborted by reset, late m_resp dropped");
        tick();
        chk("t4_m_cyc_idle", 128'(bus.m_cyc), 128'(0));
        bus.m_resp = 1'b0;
        tick();

        // 5: unsolicited m_resp while IDLE
        bus.m_resp = 1'b1; bus.m_rdata = LINE_FF;
        #1;
        chk("t5_i_resp",  128'(bus.i_resp), 128'(0));
        chk("t5_d_resp",  128'(bus.d_resp), 128'(0));
        chk("t5_d_rdata", bus.d_rdata,      128'(0));
        chk("t5_i_rdata", bus.i_rdata,      128'(0));
        $display("txn 5 unsolicited m_resp in IDLE");
        tick();
        chk("t5_m_cyc", 128'(bus.m_cyc), 128'(0));
        bus.m_resp = 1'b0;

        // 6: saturation on the 2-bit counter instance; a tie every third cycle
        bus_s.i_stb = 1'b1; bus_s.i_addr = 16'h0011;
        bus_s.d_stb = 1'b1; bus_s.d_addr = 16'h0022;
        bus_s.m_resp = 1'b1;
        tick();
        chk("t6_cnt_1", 128'(contention_s), 128'(1));
        repeat (3) tick();
        chk("t6_cnt_2", 128'(contention_s), 128'(2));
        repeat (3) tick();
        chk("t6_cnt_sat", 128'(contention_s), 128'(3));
        repeat (9) tick();
        chk("t6_cnt_no_wrap", 128'(contention_s), 128'(3));
        chk("t6_main_unaffected", 128'(contention), 128'(0));
        $display("txn 6 saturating contention=%0d", contention_s);
        bus_s.i_stb = 1'b0; bus_s.d_stb = 1'b0; bus_s.m_resp = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
